// File: rtl/read_to_sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : read_to_sdram_pkg
// Brief    : State codes and shared constants for the FX2-to-Wishbone mover.
// Revision : 1.0 - initial release
// ============================================================================
package read_to_sdram_pkg;

  localparam int DEFAULT_WORD_COUNT = 120;

  localparam logic [3:0] SEL_ALL = 4'hF;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD_LO  = 3'd1;
  localparam logic [2:0] RD_HI  = 3'd2;
  localparam logic [2:0] WB_REQ = 3'd3;
  localparam logic [2:0] WB_REL = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/read_to_sdram_fx2_slave_fifo_rd.sv
`default_nettype none
// ============================================================================
// Module   : fx2_slave_fifo_rd
// Brief    : FX2 slave-FIFO read strobes and halfword-to-word packing.
// Revision : 1.0 - initial release
// ============================================================================
module fx2_slave_fifo_rd (
  input  logic        CLKOUT,
  input  logic        rst_n,
  input  logic        FLAGA,
  input  logic [15:0] fdata,
  input  logic        rd_active,
  input  logic        rd_hi,
  output logic        SLRD,
  output logic        SLOE,
  output logic        rd_strobe,
  output logic [31:0] word
);

  logic [31:0] r_word = '0;

  // A halfword is consumed only on edges where the FIFO reports data.
  assign rd_strobe = rd_active & FLAGA;
  assign SLRD      = ~rd_strobe;
  assign SLOE      = ~rd_active;
  assign word      = r_word;

  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
    end else if (rd_strobe) begin
      if (rd_hi) begin
        r_word[31:16] <= fdata;
      end else begin
        r_word[15:0] <= fdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/read_to_sdram.sv
`default_nettype none
// ============================================================================
// Module   : read_to_sdram
// Brief    : Pulls 16-bit halfwords from an FX2 OUT FIFO, packs them into
//            32-bit words and writes them to a Wishbone slave.
//            Optional macro READ_TO_SDRAM_LED_EN enables the debug lamps.
// Revision : 1.0 - initial release
// ============================================================================
module read_to_sdram
  import read_to_sdram_pkg::*;
#(
  parameter int          WORD_COUNT = DEFAULT_WORD_COUNT,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        CLKOUT,
  input  logic        rst_n,
  input  logic        FLAGA,
  inout  wire  [15:0] FDATA,
  output logic        SLRD,
  output logic        SLOE,
  output logic        SLWR,
  output logic        IFCLK,
  output logic [1:0]  FIFOADR,
  output logic [3:0]  LED,
  output logic [2:0]  cstate,
  output logic        read_ack,
  input  logic [31:0] data_o,
  input  logic        stall_o,
  input  logic        sdram_ack,
  output logic        cyc_i,
  output logic        stb_i,
  output logic        we_i,
  output logic [3:0]  sel_i,
  output logic [31:0] addr_i,
  output logic [31:0] data_i
);

  localparam int               IDX_W      = $clog2(WORD_COUNT + 1);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(WORD_COUNT);

  logic [2:0]       r_state = IDLE;
  logic [2:0]       w_next;
  logic [IDX_W-1:0] r_index = '0;
  logic [31:0]      r_addr  = BASE_ADDR;
  logic             w_rd_active;
  logic             w_rd_hi;
  logic             w_rd_strobe;
  logic             w_unused;

  // The FX2 bus is input-only for this block.
  assign FDATA   = 16'bz;
  assign SLWR    = 1'b1;
  assign IFCLK   = CLKOUT;
  assign FIFOADR = 2'b00;
  assign cstate  = r_state;
  assign addr_i  = r_addr;

  // Write-only master: read data and stall are not needed.
  assign w_unused = &{1'b0, data_o, stall_o, w_rd_strobe};

  fx2_slave_fifo_rd u_fifo_rd (
    .CLKOUT    (CLKOUT),
    .rst_n     (rst_n),
    .FLAGA     (FLAGA),
    .fdata     (FDATA),
    .rd_active (w_rd_active),
    .rd_hi     (w_rd_hi),
    .SLRD      (SLRD),
    .SLOE      (SLOE),
    .rd_strobe (w_rd_strobe),
    .word      (data_i)
  );

  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_index <= '0;
      r_addr  <= BASE_ADDR;
    end else begin
      r_state <= w_next;
      if (r_state == WB_REQ && sdram_ack) begin
        r_index <= r_index + IDX_W'(1);
        r_addr  <= r_addr + 32'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (FLAGA) w_next = RD_LO;
      RD_LO:   if (FLAGA) w_next = RD_HI;
      RD_HI:   if (FLAGA) w_next = WB_REQ;
      WB_REQ:  if (sdram_ack) w_next = WB_REL;
      // Wait for the slave to drop ack so every transaction gets an idle cycle.
      WB_REL:  if (!sdram_ack) w_next = (r_index == C_LAST_IDX) ? DONE : RD_LO;
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_rd_active = 1'b0;
    w_rd_hi     = 1'b0;
    cyc_i       = 1'b0;
    stb_i       = 1'b0;
    we_i        = 1'b0;
    sel_i       = 4'h0;
    read_ack    = 1'b0;
    case (r_state)
      RD_LO:  w_rd_active = 1'b1;
      RD_HI: begin
        w_rd_active = 1'b1;
        w_rd_hi     = 1'b1;
      end
      WB_REQ: begin
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = 1'b1;
        sel_i = SEL_ALL;
      end
      DONE:   read_ack = 1'b1;
      default: ;
    endcase
  end

`ifdef READ_TO_SDRAM_LED_EN
  assign LED = {r_index[0], read_ack, cyc_i, w_rd_active};
`else
  assign LED = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_read_to_sdram.sv
`default_nettype none
// ============================================================================
// Module   : tb_read_to_sdram
// Brief    : Randomized FX2 source and Wishbone slave with a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_read_to_sdram;

  localparam int          WC   = 120;
  localparam logic [31:0] BASE = 32'h0;

  logic        CLKOUT = 1'b0;
  logic        rst_n  = 1'b0;
  logic        FLAGA  = 1'b0;
  wire  [15:0] FDATA;
  logic [15:0] fx2_data = 16'h0;
  logic        SLRD, SLOE, SLWR, IFCLK;
  logic [1:0]  FIFOADR;
  logic [3:0]  LED;
  logic [2:0]  cstate;
  logic        read_ack;
  logic [31:0] data_o    = 32'h0;
  logic        stall_o   = 1'b0;
  logic        sdram_ack = 1'b0;
  logic        cyc_i, stb_i, we_i;
  logic [3:0]  sel_i;
  logic [31:0] addr_i, data_i;

  assign FDATA = fx2_data;

  read_to_sdram #(.WORD_COUNT(WC), .BASE_ADDR(BASE)) dut (
    .CLKOUT(CLKOUT), .rst_n(rst_n), .FLAGA(FLAGA), .FDATA(FDATA),
    .SLRD(SLRD), .SLOE(SLOE), .SLWR(SLWR), .IFCLK(IFCLK), .FIFOADR(FIFOADR),
    .LED(LED), .cstate(cstate), .read_ack(read_ack),
    .data_o(data_o), .stall_o(stall_o), .sdram_ack(sdram_ack),
    .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .sel_i(sel_i),
    .addr_i(addr_i), .data_i(data_i)
  );

  always #5 CLKOUT = ~CLKOUT;

  int errors = 0;
  int checks = 0;
  bit in_reset  = 1'b1;
  bit force_low = 1'b1;
  bit done_flag = 1'b0;
  int words_written = 0;

  logic [63:0] expq[$];
  logic [31:0] mem [0:WC-1];

  // FX2 source state
  bit          pending = 1'b0;
  bit          have_lo = 1'b0;
  logic [15:0] lo_half = 16'h0;
  logic [31:0] words_pushed = 32'h0;
  bit          prev_stall_hi = 1'b0;

  // Wishbone slave state
  bit          active = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] hold_addr, hold_data;
  logic [63:0] exp_entry;
  logic [31:0] widx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // FX2 FIFO: an endless incrementing halfword stream, one per consumed SLRD edge.
  initial begin
    forever begin
      @(negedge CLKOUT);
      if (in_reset) begin
        pending = 1'b0; have_lo = 1'b0; words_pushed = 32'h0;
        fx2_data = 16'h0; FLAGA = 1'b0; prev_stall_hi = 1'b0;
        expq.delete();
        continue;
      end
      if (prev_stall_hi) check("rd_hi_hold", 32'(cstate), 32'd2);
      if (pending) begin
        if (have_lo) begin
          expq.push_back({BASE + words_pushed, fx2_data, lo_half});
          words_pushed = words_pushed + 32'd1;
          have_lo = 1'b0;
        end else begin
          lo_half = fx2_data;
          have_lo = 1'b1;
        end
        fx2_data = fx2_data + 16'd1;
      end
      FLAGA = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      #1;
      pending = (SLRD == 1'b0);
      prev_stall_hi = (cstate == 3'd2) && !FLAGA;
      if (done_flag) check("slrd_after_done", 32'(SLRD), 32'd1);
      else if (!FLAGA && (cstate == 3'd1 || cstate == 3'd2))
        check("slrd_high_when_empty", 32'(SLRD), 32'd1);
      if (cstate == 3'd1 || cstate == 3'd2) check("sloe_low_in_read", 32'(SLOE), 32'd0);
    end
  end

  // Wishbone slave with random latency/stall; pops the scoreboard on each ack.
  initial begin
    forever begin
      @(negedge CLKOUT);
      #2;
      if (in_reset) begin
        sdram_ack = 1'b0; stall_o = 1'b0; active = 1'b0; words_written = 0;
        for (int i = 0; i < WC; i++) mem[i] = 32'hDEAD_BEEF;
        continue;
      end
      if (sdram_ack) begin
        sdram_ack = 1'b0;
        active = 1'b0;
        check("idle_gap_cyc", 32'(cyc_i), 32'd0);
      end else if (cyc_i && stb_i) begin
        if (!active) begin
          active = 1'b1;
          hold_addr = addr_i;
          hold_data = data_i;
          wait_cnt = ($urandom_range(0, 2) == 0) ? 5 : int'($urandom_range(0, 7));
          check("we", 32'(we_i), 32'd1);
          check("sel", 32'(sel_i), 32'hF);
        end else begin
          check("addr_stable", addr_i, hold_addr);
          check("data_stable", data_i, hold_data);
        end
        if (wait_cnt == 0) begin
          stall_o = 1'b0;
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: got write %h@%h expected none", data_i, addr_i);
          end else begin
            exp_entry = expq.pop_front();
            check("wr_addr", addr_i, exp_entry[63:32]);
            check("wr_data", data_i, exp_entry[31:0]);
          end
          if (words_written == 0) begin
            check("first_addr", addr_i, BASE);
            check("first_data", data_i, 32'h0001_0000);
          end
          widx = addr_i - BASE;
          if (widx < WC) mem[widx] = data_i;
          words_written++;
          sdram_ack = 1'b1;
        end else begin
          wait_cnt--;
          stall_o = ($urandom_range(0, 3) == 0);
        end
      end
    end
  end

  initial begin : main
    bit hit;
    repeat (3) @(negedge CLKOUT);
    #3;
    check("rst_cstate", 32'(cstate), 32'd0);
    check("rst_cyc", 32'(cyc_i), 32'd0);
    check("rst_stb_we", 32'({stb_i, we_i}), 32'd0);
    check("rst_sel", 32'(sel_i), 32'd0);
    check("rst_addr", addr_i, BASE);
    check("rst_data", data_i, 32'd0);
    check("rst_strobes", 32'({SLRD, SLOE, SLWR}), 32'd7);
    check("rst_read_ack", 32'(read_ack), 32'd0);
    check("rst_led", 32'(LED), 32'd0);
    check("fifoadr", 32'(FIFOADR), 32'd0);
    check("ifclk", 32'(IFCLK), 32'(CLKOUT));
    rst_n = 1'b1; in_reset = 1'b0; force_low = 1'b1;

    // FIFO empty after start: must sit in IDLE with no bus activity.
    repeat (3) begin
      @(negedge CLKOUT); #3;
      check("empty_cstate", 32'(cstate), 32'd0);
      check("empty_slrd", 32'(SLRD), 32'd1);
      check("empty_cyc", 32'(cyc_i), 32'd0);
    end
    force_low = 1'b0;

    // Reset in the middle of a bus request.
    hit = 1'b0;
    for (int c = 0; c < 5000 && !hit; c++) begin
      @(negedge CLKOUT); #3;
      if (words_written >= 3 && cstate == 3'd3) hit = 1'b1;
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL wait_wb_req: got timeout expected WB_REQ after 3 words");
    end else begin
      check("pre_rst_cyc", 32'(cyc_i), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_cyc", 32'(cyc_i), 32'd0);
      check("midrst_cstate", 32'(cstate), 32'd0);
      check("midrst_data", data_i, 32'd0);
      check("midrst_addr", addr_i, BASE);
      in_reset = 1'b1;
      repeat (2) @(negedge CLKOUT);
      #3;
      rst_n = 1'b1; in_reset = 1'b0;
    end

    hit = 1'b0;
    for (int c = 0; c < 30000 && !hit; c++) begin
      @(negedge CLKOUT); #3;
      if (read_ack) hit = 1'b1;
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL wait_read_ack: got timeout expected read_ack=1");
    end else begin
      done_flag = 1'b1;
      repeat (20) begin
        @(negedge CLKOUT); #3;
        check("done_cstate", 32'(cstate), 32'd5);
        check("done_read_ack", 32'(read_ack), 32'd1);
        check("done_cyc", 32'(cyc_i), 32'd0);
      end
      check("words_written", 32'(words_written), 32'(WC));
      check("scoreboard_left", 32'(expq.size()), 32'd0);
      for (int n = 0; n < WC; n++)
        check($sformatf("mem[%0d]", n), mem[n], {16'(2 * n + 1), 16'(2 * n)});
`ifdef READ_TO_SDRAM_LED_EN
      check("done_led", 32'(LED), 32'h4);
`else
      check("done_led", 32'(LED), 32'h0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/read_to_sdram.md
READ_TO_SDRAM -- requirements
Module: read_to_sdram

Interface
REQ-001 Parameter WORD_COUNT, default 120: number of 32-bit words transferred before completion.
REQ-002 Parameter BASE_ADDR, default 32'h0: first Wishbone word address.
REQ-003 CLKOUT  in  1  sole clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 FLAGA  in  1  FX2 OUT-FIFO not-empty flag; 1 = data available.
REQ-006 FDATA  inout  16  FX2 data bus; DUT never drives it (constant high-Z); read only.
REQ-007 SLRD, SLOE, SLWR  out  1 each  FX2 strobes, active-low; SLWR constant 1.
REQ-008 IFCLK  out  1  equals CLKOUT.
REQ-009 FIFOADR  out  2  constant 2'b00.
REQ-010 LED  out  4  debug lamps; cstate  out  3  current state code; read_ack  out  1  transfer complete.
REQ-011 data_o  in  32, stall_o  in  1, sdram_ack  in  1  Wishbone slave outputs.
REQ-012 cyc_i, stb_i, we_i  out  1 each; sel_i  out  4; addr_i  out  32; data_i  out  32  Wishbone master outputs.

Function
REQ-013 States/codes: IDLE=0, RD_LO=1, RD_HI=2, WB_REQ=3, WB_REL=4, DONE=5; cstate shows the code.
REQ-014 IDLE -> RD_LO when FLAGA=1; otherwise stay.
REQ-015 RD_LO/RD_HI: SLOE=0; SLRD=0 combinationally when FLAGA=1, else SLRD=1 and the state holds.
REQ-016 Halfword captured from FDATA on the rising edge where SLRD=0: RD_LO -> data_i[15:0], then RD_HI; RD_HI -> data_i[31:16], then WB_REQ.
REQ-017 WB_REQ: cyc_i=stb_i=we_i=1, sel_i=4'hF, addr_i=BASE_ADDR+word index; addr_i and data_i stable for the whole cycle.
REQ-018 stall_o=1 holds stb_i asserted; no state change.
REQ-019 sdram_ack=1 sampled in WB_REQ -> word index +1, go to WB_REL; any latency accepted, no timeout.
REQ-020 WB_REL: cyc_i=stb_i=we_i=0; wait until sdram_ack=0, then DONE if index==WORD_COUNT, else RD_LO. Minimum one idle bus cycle between transactions.
REQ-021 DONE: read_ack=1, SLRD=SLOE=1, no bus activity; held until reset.
REQ-022 Word index width clog2(WORD_COUNT+1); it never wraps.
REQ-023 data_o unused (write-only master).

Reset
REQ-024 rst_n=0 asynchronously forces IDLE, index=0, data_i=0, addr_i=BASE_ADDR, cyc_i=stb_i=we_i=0, sel_i=0, SLRD=SLOE=SLWR=1, read_ack=0, LED=0.
REQ-025 All registers carry power-up initial values equal to their reset values, so the block runs with rst_n held high.
REQ-026 Reset mid-transaction drops cyc_i immediately; any partial word is discarded.

Configuration
REQ-027 Macro READ_TO_SDRAM_LED_EN.
- Defined: LED[0]=in RD_LO/RD_HI, LED[1]=cyc_i, LED[2]=read_ack, LED[3]=index[0].
- Undefined: LED=4'b0000 and no LED logic is generated.

Structure
REQ-028 Package read_to_sdram_pkg holds the state codes, SEL_ALL=4'hF and the default WORD_COUNT.
REQ-029 One sub-module, fx2_slave_fifo_rd, generates SLRD/SLOE and captures/packs the halfwords. Top level holds the Wishbone FSM.

Verification
REQ-030 FLAGA=0 for 3 cycles after start -> cstate=0, SLRD=1, cyc_i=0.
REQ-031 FX2 model incrementing FDATA per SLRD edge from 0 -> first write addr 0, data_i=32'h0001_0000, sel_i=4'hF, we_i=1.
REQ-032 Slave acks 5 cycles after stb_i -> cyc_i, addr_i and data_i unchanged until ack; cyc_i low at least one cycle before the next stb_i.
REQ-033 FLAGA=0 while in RD_HI -> SLRD=1, cstate=2 held; resumes on FLAGA=1 with no lost or duplicated halfword.
REQ-034 Full run, WORD_COUNT=120 -> memory[n]={2n+1,2n} for n=0..119; read_ack=1; cstate=5; no further SLRD pulses.
REQ-035 rst_n pulsed low during WB_REQ -> cyc_i=0 immediately; restart writes from address 0.
